// File: rtl/event_order_checker.sv
// Checks that single-cycle event pulses arrive strictly in index order.
// Ports: clk, rst, start_i, ev_i in; busy_o, done_o, pass_o, fail_code_o,
//   fail_idx_o out; pass_cnt_o, fail_cnt_o when EVT_ORDER_STATS_EN is defined.
module event_order_checker #(
  parameter int NUM_EV  = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [NUM_EV-1:0]         ev_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [1:0]                fail_code_o,
  output logic [$clog2(NUM_EV)-1:0] fail_idx_o
`ifdef EVT_ORDER_STATS_EN
  ,
  output logic [CNT_W-1:0]          pass_cnt_o,
  output logic [CNT_W-1:0]          fail_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_EV);
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_EV - 1);
  localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT);

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_ORD  = 2'd1;
  localparam logic [1:0] CODE_TO   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] exp_q, exp_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             pass_q, pass_d;
  logic [1:0]       code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Lowest set event index above the expected one.
  logic             hi_hit;
  logic [IDX_W-1:0] hi_idx;

  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    // Scan downward so the last hit kept is the lowest index.
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (ev_i[i] && (i > int'(exp_q))) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    code_d  = code_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ARMED;
          exp_d   = '0;
          timer_d = '0;
        end
      end
      ARMED: begin
        if (hi_hit) begin
          state_d = REPORT;
          pass_d  = 1'b0;
          code_d  = CODE_ORD;
          idx_d   = hi_idx;
        end else if (ev_i[exp_q]) begin
          if (exp_q == LAST) begin
            state_d = REPORT;
            pass_d  = 1'b1;
            code_d  = CODE_NONE;
            idx_d   = '0;
          end else begin
            exp_d   = exp_q + 1'b1;
            timer_d = '0;
          end
        end else if (TIMEOUT != 0) begin
          // Repeats of matched events land here and keep counting.
          if (timer_q != TMAX) begin
            timer_d = timer_q + 1'b1;
          end
          if (timer_d == TMAX) begin
            state_d = REPORT;
            pass_d  = 1'b0;
            code_d  = CODE_TO;
            idx_d   = exp_q;
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      timer_q <= '0;
      pass_q  <= 1'b0;
      code_q  <= CODE_NONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o      = (state_q == ARMED);
  assign done_o      = (state_q == REPORT);
  assign pass_o      = pass_q;
  assign fail_code_o = code_q;
  assign fail_idx_o  = idx_q;

`ifdef EVT_ORDER_STATS_EN
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (done_o && pass_q && (pcnt_q != '1)) begin
      pcnt_d = pcnt_q + 1'b1;
    end
    if (done_o && !pass_q && (fcnt_q != '1)) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign pass_cnt_o = pcnt_q;
  assign fail_cnt_o = fcnt_q;
`endif

endmodule

// File: tb/tb_event_order_checker.sv
// Scoreboard bench for event_order_checker with a sequence-level model.
// Driver pushes expected results; a negedge monitor pops on done_o.
module tb_event_order_checker;

  localparam int NUM_EV  = 3;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [2:0] ev_i;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [1:0] fail_code_o;
  logic [1:0] fail_idx_o;
`ifdef EVT_ORDER_STATS_EN
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] fail_cnt_o;
`endif

  event_order_checker #(
    .NUM_EV (NUM_EV),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .ev_i       (ev_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_code_o(fail_code_o),
    .fail_idx_o (fail_idx_o)
`ifdef EVT_ORDER_STATS_EN
    ,
    .pass_cnt_o (pass_cnt_o),
    .fail_cnt_o (fail_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         pass;
    logic [1:0] code;
    logic [1:0] idx;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  int   checks   = 0;
  int   failures = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req,
               $time);
    end
  endtask

  function automatic logic [2:0] vec_at(input logic [2:0] v[$], input int t);
    return (t < v.size()) ? v[t] : 3'd0;
  endfunction

  // Walks the event sequence against the ordering rules; d is the
  // index of the deciding vector.
  function automatic exp_t model(input logic [2:0] v[$], output int d);
    exp_t r;
    int   e     = 0;
    int   quiet = 0;
    r.pass = 1'b0;
    r.code = 2'd0;
    r.idx  = 2'd0;
    r.at   = 0;
    d      = 0;
    for (int t = 0; t < 1000; t++) begin
      logic [2:0] x;
      int         hit;
      x   = vec_at(v, t);
      hit = -1;
      for (int j = NUM_EV - 1; j > e; j--) if (x[j]) hit = j;
      d = t;
      if (hit >= 0) begin
        r.code = 2'd1;
        r.idx  = 2'(hit);
        return r;
      end
      if (x[e]) begin
        if (e == NUM_EV - 1) begin
          r.pass = 1'b1;
          return r;
        end
        e++;
        quiet = 0;
      end else begin
        quiet++;
        if (quiet == TIMEOUT) begin
          r.code = 2'd2;
          r.idx  = 2'(e);
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic run(input logic [2:0] v[$]);
    exp_t r;
    int   d;
    r = model(v, d);
    @(posedge clk);
    #1;
    check("hold_pass", 32'(pass_o), 32'(last.pass));
    check("hold_code", 32'(fail_code_o), 32'(last.code));
    check("hold_idx", 32'(fail_idx_o), 32'(last.idx));
    start_i = 1'b1;
    ev_i    = 3'($urandom);
    r.at    = cyc + 2 + d;
    sbq.push_back(r);
    last = r;
    for (int t = 0; t <= d; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) check("busy_armed", 32'(busy_o), 32'd1);
      start_i = 1'($urandom);
      ev_i    = vec_at(v, t);
    end
    @(posedge clk);
    #1;
    start_i = 1'($urandom);
    ev_i    = 3'($urandom);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      ev_i = 3'($urandom);
      @(posedge clk);
      #1;
    end
    ev_i = 3'd0;
  endtask

  task automatic run_random();
    logic [2:0] v[$];
    int         len;
    int         eg;
    len = $urandom_range(1, 30);
    eg  = 0;
    for (int i = 0; i < len; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4) begin
        v.push_back(3'd0);
      end else if (k < 7) begin
        v.push_back(3'(1 << eg));
        if (eg < NUM_EV - 1) eg++;
      end else if (k == 7 && eg > 0) begin
        v.push_back(3'(1 << $urandom_range(0, eg - 1)));
      end else begin
        v.push_back(3'($urandom));
      end
    end
    run(v);
  endtask

  task automatic reset_mid_check();
    @(posedge clk);
    #1;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ev_i    = 3'b001;
    @(posedge clk);
    #1;
    ev_i = 3'b010;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_code", 32'(fail_code_o), 32'd0);
    check("rst_idx", 32'(fail_idx_o), 32'd0);
`ifdef EVT_ORDER_STATS_EN
    check("rst_pcnt", 32'(pass_cnt_o), 32'd0);
    check("rst_fcnt", 32'(fail_cnt_o), 32'd0);
`endif
    ev_i = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    ev_i   = 3'd0;
    last   = '{1'b0, 2'd0, 2'd0, 0};
    n_pass = 0;
    n_fail = 0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_busy", 32'(busy_o), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.at));
        check("pass", 32'(pass_o), 32'(e.pass));
        check("fail_code", 32'(fail_code_o), 32'(e.code));
        if (!e.pass) check("fail_idx", 32'(fail_idx_o), 32'(e.idx));
        check("busy_at_done", 32'(busy_o), 32'd0);
        if (e.pass) n_pass++;
        else n_fail++;
      end
    end
  end

  initial begin
    logic [2:0] q[$];
    rst     = 1'b1;
    start_i = 1'b0;
    ev_i    = 3'd0;
    last    = '{1'b0, 2'd0, 2'd0, 0};
    #12;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_pass", 32'(pass_o), 32'd0);
    check("reset_code", 32'(fail_code_o), 32'd0);
    check("reset_idx", 32'(fail_idx_o), 32'd0);
    #3;
    rst = 1'b0;

    q = '{3'd0, 3'd0, 3'b001, 3'd0, 3'b010, 3'd0, 3'b100};
    run(q);
    q = '{3'b001, 3'd0, 3'b100};
    run(q);
    q = '{3'b001, 3'b110};
    run(q);
    q = '{3'b011};
    run(q);
    q = '{3'b001};
    run(q);
    q = '{3'd0, 3'd0};
    run(q);
    q = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
    run(q);
    q = '{3'b001, 3'b011, 3'b001, 3'b010, 3'b100};
    run(q);
    q = '{3'b111};
    run(q);

    for (int i = 0; i < 60; i++) run_random();

    reset_mid_check();

    for (int i = 0; i < 20; i++) run_random();

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
`ifdef EVT_ORDER_STATS_EN
    check("pass_cnt", 32'(pass_cnt_o), 32'((n_pass > 255) ? 255 : n_pass));
    check("fail_cnt", 32'(fail_cnt_o), 32'((n_fail > 255) ? 255 : n_fail));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
